// File: rtl/div_pkg.sv
// Shared definitions for the arbitrated divider: controller state encoding
// and the default operand width.
package div_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    QI = 2'd0,
    QC = 2'd1,
    QD = 2'd2
  } state_t;

endpackage

// File: rtl/div_core_8.sv
// Repeated-subtraction divider datapath: operand registers, result registers
// and the compare/subtract step. Sequencing comes from the arbiter FSM.
module div_core_8
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             board_clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             compute,
  input  logic [WIDTH-1:0] x_load,
  input  logic [WIDTH-1:0] y_load,
  output logic             finish,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_zero_reg;
  logic             y_zero;
  logic             x_lt_y;

  assign y_zero = (y_reg == '0);
  assign x_lt_y = (x_reg < y_reg);
  // A zero divisor ends the operation immediately; otherwise stop once X < Y.
  assign finish = y_zero | x_lt_y;

  always_ff @(posedge board_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg         <= '0;
      y_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
    end else if (load) begin
      x_reg        <= x_load;
      y_reg        <= y_load;
      quotient_reg <= '0;
      div_zero_reg <= 1'b0;
    end else if (compute) begin
      if (y_zero) begin
        div_zero_reg  <= 1'b1;
        quotient_reg  <= '1;
        remainder_reg <= x_reg;
      end else if (!x_lt_y) begin
        x_reg        <= x_reg - y_reg;
        quotient_reg <= quotient_reg + ONE;
      end else begin
        remainder_reg <= x_reg;
      end
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: rtl/div_arbiter_8.sv
// Two-requester front end for the shared divider: round-robin arbitration on
// ties, QI/QC/QD controller, and per-requester grant/done handshake.
module div_arbiter_8
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             ClkPort,
  input  logic             Reset_n,
  input  logic             Start0,
  input  logic             Start1,
  input  logic             Ack0,
  input  logic             Ack1,
  input  logic [WIDTH-1:0] Xin0,
  input  logic [WIDTH-1:0] Yin0,
  input  logic [WIDTH-1:0] Xin1,
  input  logic [WIDTH-1:0] Yin1,
  output logic             Grant0,
  output logic             Grant1,
  output logic             Done0,
  output logic             Done1,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Qi,
  output logic             Qc,
  output logic             Qd
);

  state_t state_reg, state_next;
  logic   grant0_reg, grant0_next;
  logic   grant1_reg, grant1_next;
  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic   last_grant_reg, last_grant_next;

  logic             win1;
  logic             ack_hit;
  logic             load;
  logic             compute;
  logic             finish;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] y_sel;
  logic [1:0]       grant_vec;
  logic [1:0]       done_vec;

  assign win1    = Start1 & (~Start0 | ~last_grant_reg);
  assign x_sel   = win1 ? Xin1 : Xin0;
  assign y_sel   = win1 ? Yin1 : Yin0;
  assign ack_hit = (grant0_reg & Ack0) | (grant1_reg & Ack1);

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= QI;
      grant0_reg     <= 1'b0;
      grant1_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      grant0_reg     <= grant0_next;
      grant1_reg     <= grant1_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant0_next     = grant0_reg;
    grant1_next     = grant1_reg;
    last_grant_next = last_grant_reg;
    load            = 1'b0;
    compute         = 1'b0;
    case (state_reg)
      QI: begin
        if (Start0 | Start1) begin
          load            = 1'b1;
          grant0_next     = ~win1;
          grant1_next     = win1;
          last_grant_next = win1;
          state_next      = QC;
        end
      end
      QC: begin
        compute = 1'b1;
        if (finish) state_next = QD;
      end
      QD: begin
        if (ack_hit) begin
          grant0_next = 1'b0;
          grant1_next = 1'b0;
          state_next  = QI;
        end
      end
      default: state_next = QI;
    endcase
  end

  div_core_8 #(
    .WIDTH(WIDTH)
  ) u_core (
    .board_clk(ClkPort),
    .reset_n  (Reset_n),
    .load     (load),
    .compute  (compute),
    .x_load   (x_sel),
    .y_load   (y_sel),
    .finish   (finish),
    .quotient (Quotient),
    .remainder(Remainder),
    .div_zero (DivZero)
  );

  assign grant_vec = {grant1_reg, grant0_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_done
    assign done_vec[gi] = (state_reg == QD) & grant_vec[gi];
  end

  assign Grant0 = grant0_reg;
  assign Grant1 = grant1_reg;
  assign Done0  = done_vec[0];
  assign Done1  = done_vec[1];
  assign Qi     = (state_reg == QI);
  assign Qc     = (state_reg == QC);
  assign Qd     = (state_reg == QD);

endmodule

// File: tb/tb_div_arbiter_8.sv
// Bench for div_arbiter_8: directed scenarios plus random traffic, all checked
// every cycle against an operation-level model of the arbitrated divider.
module tb_div_arbiter_8;

  logic       ClkPort = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start0 = 1'b0, Start1 = 1'b0, Ack0 = 1'b0, Ack1 = 1'b0;
  logic [7:0] Xin0 = '0, Yin0 = '0, Xin1 = '0, Yin1 = '0;
  logic       Grant0, Grant1, Done0, Done1, DivZero, Qi, Qc, Qd;
  logic [7:0] Quotient, Remainder;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  div_arbiter_8 #(.WIDTH(8)) dut (
    .ClkPort(ClkPort), .Reset_n(Reset_n),
    .Start0(Start0), .Start1(Start1), .Ack0(Ack0), .Ack1(Ack1),
    .Xin0(Xin0), .Yin0(Yin0), .Xin1(Xin1), .Yin1(Yin1),
    .Grant0(Grant0), .Grant1(Grant1), .Done0(Done0), .Done1(Done1),
    .Quotient(Quotient), .Remainder(Remainder), .DivZero(DivZero),
    .Qi(Qi), .Qc(Qc), .Qd(Qd)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model: idle / computing for a known number of cycles / done.
  int         m_state = 0;
  logic       m_g0 = 1'b0, m_g1 = 1'b0, m_last = 1'b1, m_dz = 1'b0, m_pick1;
  logic [7:0] m_x, m_y, m_q = '0, m_r = '0;
  int         m_left, m_elapsed;

  initial begin
    forever begin
      @(posedge ClkPort or negedge Reset_n);
      if (!Reset_n) begin
        m_state = 0; m_g0 = 0; m_g1 = 0; m_last = 1;
        m_q = '0; m_r = '0; m_dz = 0;
      end else begin
        case (m_state)
          0: if (Start0 || Start1) begin
            m_pick1   = Start1 && (!Start0 || !m_last);
            m_g0      = !m_pick1;
            m_g1      = m_pick1;
            m_last    = m_pick1;
            m_x       = m_pick1 ? Xin1 : Xin0;
            m_y       = m_pick1 ? Yin1 : Yin0;
            m_q       = '0;
            m_dz      = 0;
            m_elapsed = 0;
            m_left    = (m_y == 0) ? 1 : int'(m_x / m_y) + 1;
            m_state   = 1;
          end
          1: begin
            m_elapsed++;
            m_left--;
            if (m_left == 0) begin
              m_state = 2;
              if (m_y == 0) begin
                m_q = 8'hFF; m_r = m_x; m_dz = 1;
              end else begin
                m_q = m_x / m_y; m_r = m_x % m_y;
              end
            end else begin
              m_q = 8'(m_elapsed);
            end
          end
          default: if ((m_g0 && Ack0) || (m_g1 && Ack1)) begin
            m_state = 0; m_g0 = 0; m_g1 = 0;
          end
        endcase
      end
    end
  end

  always @(negedge ClkPort) begin
    if (cmp_en) begin
      check_bit("Qi", Qi, m_state == 0);
      check_bit("Qc", Qc, m_state == 1);
      check_bit("Qd", Qd, m_state == 2);
      check_bit("Grant0", Grant0, m_g0);
      check_bit("Grant1", Grant1, m_g1);
      check_bit("Done0", Done0, (m_state == 2) && m_g0);
      check_bit("Done1", Done1, (m_state == 2) && m_g1);
      check_val("Quotient", Quotient, m_q);
      check_val("Remainder", Remainder, m_r);
      check_bit("DivZero", DivZero, m_dz);
    end
  end

  task automatic wait_done(input int which, input int limit, output int qc);
    qc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge ClkPort);
      if (Qc) qc++;
      if ((which == 0 && Done0) || (which == 1 && Done1) || (which == 2 && (Done0 || Done1))) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_done_timeout requester=%0d actual=no_done required=done", which);
  endtask

  task automatic pulse_ack(input int who, input bit drop_starts);
    if (who == 0) Ack0 = 1; else Ack1 = 1;
    if (drop_starts) begin Start0 = 0; Start1 = 0; end
    @(negedge ClkPort);
    Ack0 = 0; Ack1 = 0;
  endtask

  task automatic do_reset();
    @(negedge ClkPort);
    #2 Reset_n = 0;
    @(negedge ClkPort);
    #2 Reset_n = 1;
  endtask

  int qc, who;

  initial begin
    repeat (3) @(negedge ClkPort);
    check_bit("reset_Qi", Qi, 1'b1);
    check_bit("reset_Grant0", Grant0, 1'b0);
    check_val("reset_Quotient", Quotient, 8'd0);
    #2 Reset_n = 1;
    cmp_en = 1;

    // 100 / 7
    @(negedge ClkPort);
    Start0 = 1; Xin0 = 8'd100; Yin0 = 8'd7;
    wait_done(0, 100, qc);
    $display("op req0 100/7 qc=%0d q=%0d r=%0d", qc, Quotient, Remainder);
    check_int("div100_7_qc_cycles", qc, 15);
    check_val("div100_7_q", Quotient, 8'd14);
    check_val("div100_7_r", Remainder, 8'd2);
    pulse_ack(0, 1);
    check_bit("div100_7_back_to_QI", Qi, 1'b1);

    // 45 / 0
    Start1 = 1; Xin1 = 8'd45; Yin1 = 8'd0;
    wait_done(1, 20, qc);
    $display("op req1 45/0 qc=%0d q=%0d r=%0d dz=%0b", qc, Quotient, Remainder, DivZero);
    check_int("divzero_qc_cycles", qc, 1);
    check_val("divzero_q", Quotient, 8'hFF);
    check_val("divzero_r", Remainder, 8'd45);
    check_bit("divzero_flag", DivZero, 1'b1);
    pulse_ack(1, 1);

    // Tie straight after reset, then strict alternation
    Start0 = 1; Start1 = 1; Xin0 = 8'd9; Yin0 = 8'd3; Xin1 = 8'd5; Yin1 = 8'd9;
    do_reset();
    wait_done(0, 50, qc);
    $display("op tie req0 9/3 qc=%0d q=%0d r=%0d", qc, Quotient, Remainder);
    check_bit("tie_first_grant0", Grant0, 1'b1);
    check_val("tie_q0", Quotient, 8'd3);
    check_val("tie_r0", Remainder, 8'd0);
    check_int("tie_qc0", qc, 4);
    pulse_ack(0, 0);
    check_bit("ack_same_cycle_no_grant", Grant0 | Grant1, 1'b0);
    wait_done(1, 50, qc);
    $display("op tie req1 5/9 qc=%0d q=%0d r=%0d", qc, Quotient, Remainder);
    check_val("tie_q1", Quotient, 8'd0);
    check_val("tie_r1", Remainder, 8'd5);
    check_int("tie_qc1", qc, 1);
    pulse_ack(1, 0);
    for (int k = 0; k < 4; k++) begin
      wait_done(2, 50, qc);
      who = Done1 ? 1 : 0;
      $display("op alternate k=%0d grant=%0d", k, who);
      check_int("alternate_grant", who, k % 2);
      pulse_ack(who, k == 3);
    end

    // Foreign Ack in QD is ignored
    Start0 = 1; Xin0 = 8'd9; Yin0 = 8'd3;
    wait_done(0, 50, qc);
    Start0 = 0;
    pulse_ack(1, 0);
    $display("op foreign ack qd=%0b done0=%0b", Qd, Done0);
    check_bit("foreign_ack_stays_QD", Qd, 1'b1);
    check_bit("foreign_ack_done0", Done0, 1'b1);
    pulse_ack(0, 0);
    check_bit("own_ack_QI", Qi, 1'b1);

    // Reset mid-QC, then held Start0 restarts
    Start0 = 1; Xin0 = 8'd200; Yin0 = 8'd1;
    qc = 0;
    for (int i = 0; i < 100 && qc < 50; i++) begin
      @(negedge ClkPort);
      if (Qc) qc++;
    end
    #2 Reset_n = 0;
    #1;
    check_bit("midqc_reset_Qi", Qi, 1'b1);
    check_bit("midqc_reset_Grant0", Grant0, 1'b0);
    check_val("midqc_reset_q", Quotient, 8'd0);
    check_val("midqc_reset_r", Remainder, 8'd0);
    check_bit("midqc_reset_done0", Done0, 1'b0);
    @(negedge ClkPort);
    #2 Reset_n = 1;
    wait_done(0, 400, qc);
    $display("op restart 200/1 qc=%0d q=%0d r=%0d", qc, Quotient, Remainder);
    check_val("restart_q", Quotient, 8'd200);
    check_val("restart_r", Remainder, 8'd0);
    check_int("restart_qc", qc, 201);
    pulse_ack(0, 1);

    // Random traffic, including occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge ClkPort);
      Start0 = ($urandom_range(0, 2) != 0);
      Start1 = ($urandom_range(0, 2) != 0);
      Ack0   = ($urandom_range(0, 2) == 0);
      Ack1   = ($urandom_range(0, 2) == 0);
      Xin0   = 8'($urandom_range(0, 255));
      Xin1   = 8'($urandom_range(0, 255));
      Yin0   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, ($urandom_range(0, 1) != 0) ? 8 : 255));
      Yin1   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, ($urandom_range(0, 1) != 0) ? 8 : 255));
      if (!Reset_n) begin
        #2 Reset_n = 1;
      end else if ($urandom_range(0, 499) == 0) begin
        #2 Reset_n = 0;
      end
    end
    Start0 = 0; Start1 = 0; Ack0 = 0; Ack1 = 0;
    repeat (2) @(negedge ClkPort);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_arbiter_8.md
DIV_ARBITER_8 -- requirements
Module: div_arbiter_8

Interface
REQ-001: The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002: The block SHALL have port ClkPort, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003: The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004: The block SHALL have ports Start0 and Start1, input, 1 bit each: level requests from requester 0 and requester 1.
REQ-005: The block SHALL have ports Ack0 and Ack1, input, 1 bit each: result acknowledges from requester 0 and requester 1.
REQ-006: The block SHALL have ports Xin0, Yin0, Xin1 and Yin1, input, WIDTH bits each: dividend and divisor for each requester.
REQ-007: The block SHALL have ports Grant0 and Grant1, output, 1 bit each: the requester currently owns the divider.
REQ-008: The block SHALL have ports Done0 and Done1, output, 1 bit each: the granted requester's result is valid.
REQ-009: The block SHALL have ports Quotient and Remainder, output, WIDTH bits each: the shared result registers.
REQ-010: The block SHALL have port DivZero, output, 1 bit: the last operation had divisor 0.
REQ-011: The block SHALL have ports Qi, Qc and Qd, output, 1 bit each: one-hot state indicators for the LEDs.

Function
REQ-012: The controller SHALL be a three-state FSM with states QI (initial), QC (compute) and QD (done); exactly one of Qi, Qc or Qd SHALL be 1 at all times.
REQ-013: In QI, if exactly one Start is 1, that requester SHALL win; if both are 1, the requester not recorded in the LastGrant register SHALL win.
REQ-014: On the edge leaving QI, the block SHALL:
- latch the winner's Xin into X and its Yin into Y;
- clear Quotient;
- clear DivZero;
- set the winner's Grant and LastGrant;
- move to QC.
REQ-015: In QC, if Y = 0, the block SHALL set DivZero, set Quotient to all ones, set Remainder to X, and go to QD on the next edge.
REQ-016: In QC, if X >= Y, the block SHALL perform X <= X - Y and Quotient <= Quotient + 1 on each edge (one subtraction per cycle) and remain in QC.
REQ-017: In QC, if X < Y, the block SHALL set Remainder <= X and go to QD.
REQ-018: QC occupancy SHALL be floor(X/Y) + 1 cycles for Y != 0, and 1 cycle for Y = 0.
REQ-019: Done0/Done1 SHALL be Moore outputs, equal to Qd AND Grant0/Grant1 respectively.
REQ-020: In QD, Ack of the granted requester SHALL return the FSM to QI on the next edge and clear that Grant; Quotient, Remainder and DivZero SHALL hold until the next grant.
REQ-021: The Ack of the non-granted requester SHALL be ignored in every state, and any Ack SHALL be ignored in QI and QC.
REQ-022: A Start asserted while the FSM is not in QI SHALL be ignored but remain pending; a level-held Start SHALL be serviced at the next QI.
REQ-023: Operand changes on Xin/Yin after the grant edge SHALL NOT affect the operation in progress.
REQ-024: A requester holding Start and Ack high through QD SHALL be re-arbitrated in QI normally, not granted in the same cycle as the Ack.

Reset
REQ-025: Reset_n low SHALL asynchronously force:
- state QI;
- Grant0 = Grant1 = 0;
- Quotient = Remainder = 0;
- DivZero = 0;
- X = Y = 0;
- LastGrant = requester 1, so requester 0 wins the first tie.
REQ-026: Reset asserted mid-QC or mid-QD SHALL abort the operation with no Done pulse; operation SHALL resume on the first clock edge after release.

Structure
REQ-027: A shared package div_pkg SHALL hold the state encoding constants QI, QC, QD and the default WIDTH.
REQ-028: The block SHALL instantiate one sub-module, div_core_8, holding the X, Y, Quotient and Remainder registers and the compare/subtract logic; div_arbiter_8 SHALL hold the FSM, arbitration and LastGrant.

Verification
REQ-029: Start0 with Xin0=100, Yin0=7 -> Grant0 set, 15 cycles in QC, Done0=1 with Quotient=14, Remainder=2; Ack0 -> QI.
REQ-030: Start1 with Xin1=45, Yin1=0 -> one QC cycle, then Done1=1, DivZero=1, Quotient=0xFF, Remainder=45.
REQ-031: Start0 and Start1 both held from the first cycle after reset, with Xin0=9, Yin0=3 and Xin1=5, Yin1=9 -> Grant0 first (Quotient=3, Remainder=0); after Ack0, Grant1 (Quotient=0, Remainder=5, one QC cycle).
REQ-032: Both Starts held continuously, with each Ack given on Done -> grants strictly alternate 0,1,0,1 over 4 operations.
REQ-033: In QD with Grant0, pulse Ack1 -> stays in QD with Done0=1; then Ack0 -> QI.
REQ-034: Reset_n pulsed low mid-QC (Xin0=200, Yin0=1, cycle 50) -> immediately QI, Grant0=0, Quotient=0, Remainder=0; after release, held Start0 restarts and yields Quotient=200, Remainder=0.
